// File: rtl/struct_prepend_pkg.sv
// Shared stream-primitive types: prepend FSM states, header sizing helper and
// a default-width AXI-stream beat payload.
package struct_prepend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   function automatic int unsigned hdr_bytes(input int unsigned hdr_width);
      return hdr_width / 8;
   endfunction

   localparam int unsigned AXIS_DATA_W = 512;
   localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] data;
      logic [AXIS_KEEP_W-1:0] keep;
      logic                   last;
   } axis_beat_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single registered AXI-stream output stage; can_load_c tells the producer
// when a new beat may be offered without breaking the hold-while-stalled rule.
module axis_out_reg #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned KEEP_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEEP_W-1:0] in_keep,
   input  logic              in_last,
   output logic              can_load_c,
   output logic [DATA_W-1:0] m_tdata,
   output logic [KEEP_W-1:0] m_tkeep,
   output logic              m_tlast,
   output logic              m_tvalid,
   input  logic              m_tready
);

   logic [DATA_W-1:0] data_q, data_d;
   logic [KEEP_W-1:0] keep_q, keep_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;

   assign can_load_c = ~valid_q | m_tready;

   always_comb begin
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;
      if (can_load_c) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
            keep_d = in_keep;
            last_d = in_last;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign m_tdata  = data_q;
   assign m_tkeep  = keep_q;
   assign m_tlast  = last_q;
   assign m_tvalid = valid_q;

endmodule

// File: rtl/struct_prepend.sv
// Prepends a fixed-width header struct to an AXI-stream packet, shifting the
// payload up by the header byte count and flushing the spill-over carry.
module struct_prepend
   import struct_prepend_pkg::*;
#(
   parameter int unsigned BUF_DATA_WIDTH = 512,
   parameter int unsigned BUF_KEEP_WIDTH = BUF_DATA_WIDTH / 8,
   parameter int unsigned HDR_WIDTH      = 112
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [HDR_WIDTH-1:0]      s_struct_axis_tdata,
   input  logic                      s_struct_axis_tvalid,
   output logic                      s_struct_axis_tready,
   input  logic [BUF_DATA_WIDTH-1:0] s_inbuf_axis_tdata,
   input  logic [BUF_KEEP_WIDTH-1:0] s_inbuf_axis_tkeep,
   input  logic                      s_inbuf_axis_tlast,
   input  logic                      s_inbuf_axis_tvalid,
   output logic                      s_inbuf_axis_tready,
   output logic [BUF_DATA_WIDTH-1:0] m_outbuf_axis_tdata,
   output logic [BUF_KEEP_WIDTH-1:0] m_outbuf_axis_tkeep,
   output logic                      m_outbuf_axis_tlast,
   output logic                      m_outbuf_axis_tvalid,
   input  logic                      m_outbuf_axis_tready
);

   localparam int unsigned DW = BUF_DATA_WIDTH;
   localparam int unsigned KW = BUF_KEEP_WIDTH;
   localparam int unsigned HW = HDR_WIDTH;
   localparam int unsigned HB = hdr_bytes(HDR_WIDTH);

   state_e          state_q, state_d;
   logic [HW-1:0]   carry_q, carry_d;
   logic [HB-1:0]   carry_keep_q, carry_keep_d;

   logic            can_load_c;
   logic            ol_valid;
   logic [DW-1:0]   ol_data;
   logic [KW-1:0]   ol_keep;
   logic            ol_last;
   logic            fire;
   logic [HB-1:0]   spill_keep;

   // Upper header-sized slice of the incoming beat no longer fits and spills
   assign spill_keep = s_inbuf_axis_tkeep[KW-1:KW-HB];

   always_comb begin
      state_d              = state_q;
      carry_d              = carry_q;
      carry_keep_d         = carry_keep_q;
      ol_valid             = 1'b0;
      ol_data              = '0;
      ol_keep              = '0;
      ol_last              = 1'b0;
      fire                 = 1'b0;
      s_struct_axis_tready = 1'b0;
      s_inbuf_axis_tready  = 1'b0;

      case (state_q)
         IDLE: begin
            fire                 = can_load_c & s_struct_axis_tvalid & s_inbuf_axis_tvalid;
            s_struct_axis_tready = fire;
            s_inbuf_axis_tready  = fire;
            ol_data = {s_inbuf_axis_tdata[DW-HW-1:0], s_struct_axis_tdata};
            ol_keep = {s_inbuf_axis_tkeep[KW-HB-1:0], {HB{1'b1}}};
         end
         STREAM: begin
            fire                = can_load_c & s_inbuf_axis_tvalid;
            s_inbuf_axis_tready = can_load_c;
            ol_data = {s_inbuf_axis_tdata[DW-HW-1:0], carry_q};
            ol_keep = {s_inbuf_axis_tkeep[KW-HB-1:0], carry_keep_q};
         end
         FLUSH: begin
            ol_valid = can_load_c;
            ol_data  = {{(DW-HW){1'b0}}, carry_q};
            ol_keep  = {{(KW-HB){1'b0}}, carry_keep_q};
            ol_last  = 1'b1;
            if (can_load_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Shared accept path for IDLE and STREAM: update carry, decide flush
      if (fire) begin
         ol_valid     = 1'b1;
         carry_d      = s_inbuf_axis_tdata[DW-1:DW-HW];
         carry_keep_d = spill_keep;
         if (!s_inbuf_axis_tlast) begin
            state_d = STREAM;
         end else if (spill_keep == '0) begin
            ol_last = 1'b1;
            state_d = IDLE;
         end else begin
            state_d = FLUSH;
         end
      end

      if (rst) begin
         s_struct_axis_tready = 1'b0;
         s_inbuf_axis_tready  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         carry_q      <= '0;
         carry_keep_q <= '0;
      end else begin
         state_q      <= state_d;
         carry_q      <= carry_d;
         carry_keep_q <= carry_keep_d;
      end
   end

   axis_out_reg #(
      .DATA_W (DW),
      .KEEP_W (KW)
   ) u_out (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (ol_valid),
      .in_data    (ol_data),
      .in_keep    (ol_keep),
      .in_last    (ol_last),
      .can_load_c (can_load_c),
      .m_tdata    (m_outbuf_axis_tdata),
      .m_tkeep    (m_outbuf_axis_tkeep),
      .m_tlast    (m_outbuf_axis_tlast),
      .m_tvalid   (m_outbuf_axis_tvalid),
      .m_tready   (m_outbuf_axis_tready)
   );

endmodule

// File: doc/struct_prepend.md
Name: struct_prepend

Overview:
- Writer-side stream primitive and inverse of the header extractor: prepends one fixed-width struct (header) to the front of an AXI-stream packet buffer.
- Payload bytes are shifted up by HDR_BYTES lanes.
- Sits at the tail of handler pipelines, after the struct_access/struct_assign chain, producing the packet for the outbound port.

Parameters:
- BUF_DATA_WIDTH, 512, buffer data width in bits; multiple of 8.
- BUF_KEEP_WIDTH, 64, BUF_DATA_WIDTH/8.
- HDR_WIDTH, 112, struct width in bits; multiple of 8; 8 <= HDR_WIDTH < BUF_DATA_WIDTH. HDR_BYTES = HDR_WIDTH/8.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_struct_axis_tdata  in  HDR_WIDTH  header struct.
- s_struct_axis_tvalid  in  1  header valid.
- s_struct_axis_tready  out  1  header accepted.
- s_inbuf_axis_tdata  in  BUF_DATA_WIDTH  payload data.
- s_inbuf_axis_tkeep  in  BUF_KEEP_WIDTH  payload byte enables; contiguous from lane 0.
- s_inbuf_axis_tlast  in  1  last payload beat.
- s_inbuf_axis_tvalid  in  1  payload valid.
- s_inbuf_axis_tready  out  1  payload accepted.
- m_outbuf_axis_tdata  out  BUF_DATA_WIDTH  output data.
- m_outbuf_axis_tkeep  out  BUF_KEEP_WIDTH  output byte enables.
- m_outbuf_axis_tlast  out  1  last output beat.
- m_outbuf_axis_tvalid  out  1  output valid.
- m_outbuf_axis_tready  in  1  downstream ready.

Behaviour:
- Byte order: lane i carries tdata[8i+7:8i]. Header byte i = s_struct_axis_tdata[8i+7:8i] goes to output lane i. Payload byte j goes to packet byte HDR_BYTES+j.
- Output stage: single registered stage. It may load when m_tvalid=0 or m_tready=1 ("can_load").
- Reset: all m_* outputs 0, both s_*_tready 0, carry register 0, state IDLE. Reset mid-packet discards the partial packet; no output beat is completed afterwards.
- States:
  - IDLE: tready for both inputs = can_load & s_struct_tvalid & s_inbuf_tvalid; header and first payload beat are consumed in the same cycle.
    - Output beat = {payload[BUF_DATA_WIDTH-HDR_WIDTH-1:0], hdr}, keep = {keep[KEEP-HDR_BYTES-1:0], all-ones HDR_BYTES}.
    - Carry <= upper HDR_BYTES of payload and its keep.
    - Next state: if tlast and carry keep==0, output tlast=1 and stay IDLE. If tlast and carry keep!=0, go to FLUSH. If not tlast, go to STREAM.
  - STREAM: s_struct_tready=0; s_inbuf_tready=can_load.
    - On accept, output = {payload low part, carry}, keep composed the same way, and carry is updated.
    - On tlast: same flush decision as IDLE.
  - FLUSH: both treadys 0. When can_load, emit carry in lanes 0..HDR_BYTES-1, keep = carry keep, tlast=1, next state IDLE.
- Latency: first output beat valid 1 cycle after both header and first payload are valid and can_load=1.
- Throughput: 1 beat/cycle; FLUSH costs one extra cycle per packet only when last-beat bytes > BUF_KEEP_WIDTH-HDR_BYTES.
- Empty payload (single beat, tkeep=0, tlast=1): one output beat, keep = HDR_BYTES ones, tlast=1.
- Header without payload, or payload without header: nothing consumed; wait in IDLE.
- Output tdata/tkeep/tlast hold stable while m_tvalid=1 & m_tready=0 (AXI-S rule). No combinational path from m_tready to m_tvalid.
- Lanes with keep=0 in output carry don't-care data; the bench checks enabled lanes only.

Decomposition:
- Shared package (existing stream-primitives package): state enum {IDLE, STREAM, FLUSH}; localparam function for HDR_BYTES; AXI-S beat struct typedef (data/keep/last) parameterised by width.
- One natural sub-module: axis_out_reg, the single output register with can_load logic, reusable by other emit-side primitives. Everything else stays in struct_prepend.

Test Plan:
- Defaults: header 0x0011..0D (bytes 0..13), one 64-byte payload beat (keep all ones, tlast) -> beat 1 keep=all ones with header in lanes 0-13 and payload bytes 0-49 in lanes 14-63; beat 2 keep=0x3FFF holding payload bytes 50-63, tlast=1.
- 50-byte single payload beat (keep=2^50-1) -> exactly one output beat, keep all ones, tlast=1, no FLUSH. 51 bytes -> two beats, second keep=0x1.
- 3-beat payload of 64+64+10 bytes -> 3 output beats: keep all ones, all ones, then 0x00FFFFFF (24 bytes), tlast=1; byte stream equals header||payload.
- Header valid 5 cycles after payload valid -> no handshake on either input until the header arrives; then both accepted in the same cycle.
- Random m_tready (50%) over 100 back-to-back packets of 1-200 bytes -> byte-exact output, m_* stable during stalls, no lost or duplicated beats.
- Empty payload (keep=0, tlast) -> one beat, keep=0x3FFF, tlast=1. Assert rst mid-STREAM -> m_tvalid=0 immediately; next packet output is correct from IDLE.
